// File: rtl/serial_msg_bridge.sv
// UART bridge: 32-bit words from a message source go out as 4 8N1 bytes (LSB byte first);
// 4 received bytes are assembled into a word and offered to a sink through a one-entry holding register.
module serial_msg_bridge #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        sys_clk_pin,
  input  logic        sys_rst_pin,
  input  logic        uart_rx_pin,
  output logic        uart_tx_pin,
  input  logic [31:0] msg_out_get_data,
  input  logic        RDY_msg_out_get,
  output logic        EN_msg_out_get,
  output logic [31:0] msg_in_put_data,
  input  logic        RDY_msg_in_put,
  output logic        EN_msg_in_put,
  output logic        rx_frame_err,
  output logic        rx_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  // ---------------- transmit path ----------------
  state_t      tx_state_reg, tx_state_next;
  logic [15:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]  tx_bit_reg, tx_bit_next;
  logic [1:0]  tx_byte_reg, tx_byte_next;
  logic [31:0] tx_shift_reg, tx_shift_next;
  logic        tx_line_reg, tx_line_next;
  logic        tx_take;

  always_ff @(posedge sys_clk_pin or posedge sys_rst_pin) begin
    if (sys_rst_pin) begin
      tx_state_reg <= S_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_byte_reg  <= '0;
      tx_shift_reg <= '0;
      tx_line_reg  <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_byte_reg  <= tx_byte_next;
      tx_shift_reg <= tx_shift_next;
      tx_line_reg  <= tx_line_next;
    end
  end

  // The line value for each bit is loaded on the edge that enters that bit, so every bit lasts exactly CLKS_PER_BIT.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_byte_next  = tx_byte_reg;
    tx_shift_next = tx_shift_reg;
    tx_line_next  = tx_line_reg;
    tx_take       = 1'b0;
    case (tx_state_reg)
      S_IDLE: begin
        tx_line_next = 1'b1;
        if (RDY_msg_out_get) begin
          tx_take       = 1'b1;
          tx_shift_next = msg_out_get_data;
          tx_line_next  = 1'b0;
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          tx_byte_next  = '0;
          tx_state_next = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_line_next  = tx_shift_reg[0];
          tx_state_next = S_DATA;
        end else begin
          tx_cnt_next = tx_cnt_reg + 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_shift_next = {1'b0, tx_shift_reg[31:1]};
          tx_bit_next   = tx_bit_reg + 3'd1;
          if (tx_bit_reg == 3'd7) begin
            tx_line_next  = 1'b1;
            tx_state_next = S_STOP;
          end else begin
            tx_line_next = tx_shift_reg[1];
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next = '0;
          if (tx_byte_reg == 2'd3) begin
            tx_state_next = S_IDLE;
          end else begin
            tx_byte_next  = tx_byte_reg + 2'd1;
            tx_line_next  = 1'b0;
            tx_state_next = S_START;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + 16'd1;
        end
      end
      default: tx_state_next = S_IDLE;
    endcase
  end

  // The handshake is combinational on RDY, so reset must mask it directly.
  assign EN_msg_out_get = tx_take & ~sys_rst_pin;
  assign uart_tx_pin    = tx_line_reg;

  // ---------------- receive path ----------------
  logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
  state_t      rx_state_reg, rx_state_next;
  logic [15:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]  rx_bit_reg, rx_bit_next;
  logic [1:0]  rx_byte_cnt_reg, rx_byte_cnt_next;
  logic [7:0]  rx_shift_reg, rx_shift_next;
  logic [31:0] rx_word_reg, rx_word_next, rx_word_asm;
  logic        rx_pending_reg, rx_pending_next;
  logic [31:0] rx_hold_reg, rx_hold_next;
  logic        rx_frame_err_reg, rx_frame_err_next;
  logic        rx_overrun_reg, rx_overrun_next;
  logic        rx_deliver;

  always_ff @(posedge sys_clk_pin or posedge sys_rst_pin) begin
    if (sys_rst_pin) begin
      rx_meta_reg      <= 1'b1;
      rx_sync_reg      <= 1'b1;
      rx_prev_reg      <= 1'b1;
      rx_state_reg     <= S_IDLE;
      rx_cnt_reg       <= '0;
      rx_bit_reg       <= '0;
      rx_byte_cnt_reg  <= '0;
      rx_shift_reg     <= '0;
      rx_word_reg      <= '0;
      rx_pending_reg   <= 1'b0;
      rx_hold_reg      <= '0;
      rx_frame_err_reg <= 1'b0;
      rx_overrun_reg   <= 1'b0;
    end else begin
      rx_meta_reg      <= uart_rx_pin;
      rx_sync_reg      <= rx_meta_reg;
      rx_prev_reg      <= rx_sync_reg;
      rx_state_reg     <= rx_state_next;
      rx_cnt_reg       <= rx_cnt_next;
      rx_bit_reg       <= rx_bit_next;
      rx_byte_cnt_reg  <= rx_byte_cnt_next;
      rx_shift_reg     <= rx_shift_next;
      rx_word_reg      <= rx_word_next;
      rx_pending_reg   <= rx_pending_next;
      rx_hold_reg      <= rx_hold_next;
      rx_frame_err_reg <= rx_frame_err_next;
      rx_overrun_reg   <= rx_overrun_next;
    end
  end

  assign rx_deliver = rx_pending_reg & RDY_msg_in_put;

  always_comb begin
    rx_state_next     = rx_state_reg;
    rx_cnt_next       = rx_cnt_reg;
    rx_bit_next       = rx_bit_reg;
    rx_byte_cnt_next  = rx_byte_cnt_reg;
    rx_shift_next     = rx_shift_reg;
    rx_word_next      = rx_word_reg;
    rx_hold_next      = rx_hold_reg;
    rx_pending_next   = rx_pending_reg & ~rx_deliver;
    rx_frame_err_next = 1'b0;
    rx_overrun_next   = 1'b0;
    rx_word_asm       = rx_word_reg;
    rx_word_asm[{rx_byte_cnt_reg, 3'b000} +: 8] = rx_shift_reg;
    case (rx_state_reg)
      S_IDLE: begin
        if (rx_prev_reg & ~rx_sync_reg) begin
          rx_cnt_next   = '0;
          rx_state_next = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_sync_reg ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
          rx_bit_next   = rx_bit_reg + 3'd1;
          if (rx_bit_reg == 3'd7) rx_state_next = S_STOP;
        end else begin
          rx_cnt_next = rx_cnt_reg + 16'd1;
        end
      end
      S_STOP: begin
        // Leaving at the stop centre gives half a bit of margin to catch the next start edge.
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_state_next = S_IDLE;
          if (rx_sync_reg) begin
            rx_word_next     = rx_word_asm;
            rx_byte_cnt_next = rx_byte_cnt_reg + 2'd1;
            if (rx_byte_cnt_reg == 2'd3) begin
              if (rx_pending_reg & ~rx_deliver) begin
                rx_overrun_next = 1'b1;
              end else begin
                rx_hold_next    = rx_word_asm;
                rx_pending_next = 1'b1;
              end
            end
          end else begin
            rx_byte_cnt_next  = '0;
            rx_frame_err_next = 1'b1;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg + 16'd1;
        end
      end
      default: rx_state_next = S_IDLE;
    endcase
  end

  assign EN_msg_in_put   = rx_deliver;
  assign msg_in_put_data = rx_hold_reg;
  assign rx_frame_err    = rx_frame_err_reg;
  assign rx_overrun      = rx_overrun_reg;

endmodule
